// File: rtl/reg_file_pkg.sv
// Shared helpers for the multi-port register file: address-width derivation,
// the hardwired-zero register index and lane offsets into flat port vectors.
package reg_file_pkg;

    // Index of the register that reads as zero when ZERO_REG is enabled.
    localparam int ZERO_IDX = 0;

    // Number of address bits needed to select one of 'depth' registers.
    function automatic int calc_aw(input int depth);
        int aw;
        aw = 0;
        for (int n = 1; n < depth; n = n * 2) begin
            aw = aw + 1;
        end
        return (aw < 1) ? 1 : aw;
    endfunction

    // Low bit of lane 'lane' in a flat vector of 'width'-bit lanes.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Pending-write bitmap: one bit per register, set by alloc, cleared by a
// write, with alloc taking priority when both hit the same register.
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int DEPTH    = 32,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int AW       = calc_aw(DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 alloc_en,
    input  logic [AW-1:0]        alloc_addr,
    input  logic [NUM_WR-1:0]    wr_en,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    output logic [DEPTH-1:0]     pending
);

    logic [AW-1:0] wr_addr_a [NUM_WR];

    for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_wr_unpack
        assign wr_addr_a[gi] = wr_addr[lane_lo(gi, AW) +: AW];
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_bit
        if ((ZERO_REG != 0) && (gi == ZERO_IDX)) begin : g_zero
            assign pending[gi] = 1'b0;
        end else begin : g_live
            logic bit_q;
            logic bit_d;
            logic set_hit;
            logic clr_hit;

            // Any write port landing on this register retires its producer.
            always_comb begin
                clr_hit = 1'b0;
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wr_en[j] && (wr_addr_a[j] == AW'(gi))) begin
                        clr_hit = 1'b1;
                    end
                end
            end

            assign set_hit = alloc_en && (alloc_addr == AW'(gi));
            // A new producer issued this cycle outranks the retiring one.
            assign bit_d   = set_hit | (bit_q & ~clr_hit);

            // Pending bit register, cleared by reset.
            always_ff @(posedge clock) begin
                if (reset) begin
                    bit_q <= 1'b0;
                end else begin
                    bit_q <= bit_d;
                end
            end

            assign pending[gi] = bit_q;
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with write-to-read bypass, optional hardwired
// zero register and a pending-write scoreboard for RAW hazard stalls.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int AW       = calc_aw(DEPTH)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*AW-1:0]     wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     alloc_en,
    input  logic [AW-1:0]            alloc_addr,
    output logic [DEPTH-1:0]         pending
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_addr_a [NUM_WR];
    logic [DATA_W-1:0] wr_data_a [NUM_WR];

    for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_wr_unpack
        assign wr_addr_a[gi] = wr_addr[lane_lo(gi, AW) +: AW];
        assign wr_data_a[gi] = wr_data[lane_lo(gi, DATA_W) +: DATA_W];
    end

    // Array update: later ports overwrite earlier ones, so the highest index wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && !((ZERO_REG != 0) && (wr_addr_a[j] == AW'(ZERO_IDX)))) begin
                    mem_q[wr_addr_a[j]] <= wr_data_a[j];
                end
            end
        end
    end

    reg_file_scoreboard #(
        .DEPTH    (DEPTH),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_scoreboard (
        .clock      (clock),
        .reset      (reset),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .pending    (pending)
    );

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] data;
        logic              hit;
        logic              is_zero;

        assign addr = rd_addr[lane_lo(gi, AW) +: AW];

        // Bypass mux: same-cycle write data overrides storage; suppressed in reset.
        always_comb begin
            hit  = 1'b0;
            data = mem_q[addr];
            if (!reset) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wr_en[j] && (wr_addr_a[j] == addr)) begin
                        hit  = 1'b1;
                        data = wr_data_a[j];
                    end
                end
            end
        end

        assign is_zero = (ZERO_REG != 0) && (addr == AW'(ZERO_IDX));
        assign rd_data[lane_lo(gi, DATA_W) +: DATA_W] = is_zero ? '0 : data;
        // A bypass hit means the producer is delivering now, so no stall.
        assign rd_busy[gi] = !reset && !is_zero && pending[addr] && !hit;
    end

endmodule
